// File: rtl/pi_ctrl_if.sv
// pi_ctrl_if: CONO/CONI, device request and CPU handshake signals of the priority-interrupt controller
interface pi_ctrl_if;
  logic pi_wr;
  logic [0:35] dp;
  logic [1:7] bus_pi_req_in;
  logic pi_ack;
  logic pi_dismiss;
  logic pi_req;
  logic [0:2] pi_lev;
  logic [0:2] pi_cur;
  logic [0:35] pi_status;
  modport master (
    output pi_wr, dp, bus_pi_req_in, pi_ack, pi_dismiss,
    input  pi_req, pi_lev, pi_cur, pi_status
  );
  modport slave (
    input  pi_wr, dp, bus_pi_req_in, pi_ack, pi_dismiss,
    output pi_req, pi_lev, pi_cur, pi_status
  );
endinterface

// File: rtl/pi_ctrl.sv
// pi_ctrl: KS-10 seven-level priority-interrupt controller; define PI_SYNC_EN to add SYNC_STAGES request synchronizer flops
module pi_ctrl #(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst,
  input logic clken,
  pi_ctrl_if.slave pi
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_nx;
  logic [1:7] prog, hold, lvl_on, prog_nx, hold_nx, lvl_nx, req, pend, elig, lmask;
  logic sys_on, sys_nx, clr, ack;
  logic [0:2] cur_lev, lev_nx, cur, best;
  function automatic logic [0:2] first(input logic [1:7] v);
    first = 3'd0;
    for (int i = 7; i >= 1; i--) if (v[i]) first = 3'(i);
  endfunction
`ifdef PI_SYNC_EN
  logic [1:7] sync [SYNC_STAGES];
  always_ff @(posedge clk)
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
    end else if (clken) begin
      sync[0] <= pi.bus_pi_req_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
    end
  assign req = sync[SYNC_STAGES-1];
`else
  assign req = pi.bus_pi_req_in;
`endif
  always_comb begin
    lmask = pi.dp[29:35];
    pend = (req | prog) & lvl_on & {7{sys_on}};
    cur = first(hold);
    for (int i = 1; i <= 7; i++) elig[i] = pend[i] & (cur == 3'd0 || 3'(i) < cur);
    best = first(elig);
    clr = pi.pi_wr & pi.dp[23];
    ack = (state == REQ) & pi.pi_ack;
    prog_nx = clr ? '0 : pi.pi_wr ? (prog & ~({7{pi.dp[22]}} & lmask)) | ({7{pi.dp[24]}} & lmask) : prog;
    lvl_nx = clr ? '0 : pi.pi_wr ? (lvl_on | ({7{pi.dp[25]}} & lmask)) & ~({7{pi.dp[26]}} & lmask) : lvl_on;
    sys_nx = clr ? 1'b0 : (pi.pi_wr & pi.dp[28]) ? 1'b1 : (pi.pi_wr & pi.dp[27]) ? 1'b0 : sys_on;
    hold_nx = hold;
    if (pi.pi_dismiss && cur != 3'd0) hold_nx[cur] = 1'b0;
    if (ack) hold_nx[cur_lev] = 1'b1;
    if (clr) hold_nx = '0;
    state_nx = clr ? IDLE : (state == IDLE) ? (best != 3'd0 ? REQ : IDLE) : (!pi.pi_ack && pend[cur_lev] ? REQ : IDLE);
    lev_nx = (state == IDLE && best != 3'd0) ? best : cur_lev;
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state <= IDLE;
      prog <= '0;
      hold <= '0;
      lvl_on <= '0;
      sys_on <= 1'b0;
      cur_lev <= '0;
    end else if (clken) begin
      state <= state_nx;
      prog <= prog_nx;
      hold <= hold_nx;
      lvl_on <= lvl_nx;
      sys_on <= sys_nx;
      cur_lev <= lev_nx;
    end
  assign pi.pi_req = state == REQ;
  assign pi.pi_lev = (state == REQ) ? cur_lev : 3'd0;
  assign pi.pi_cur = cur;
  assign pi.pi_status = {11'b0, prog, 3'b0, hold, sys_on, lvl_on};
endmodule

// File: tb/tb_pi_ctrl.sv
// tb_pi_ctrl: directed and randomized checks of pi_ctrl against a level-array reference model
module tb_pi_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clken = 1'b0;
  pi_ctrl_if pi();
  pi_ctrl #(.SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .clken(clken), .pi(pi));
  always #5 clk = ~clk;
  int n_run = 0;
  int n_fail = 0;
  bit m_prog [1:7];
  bit m_hold [1:7];
  bit m_on [1:7];
  bit m_sys, m_offer;
  int m_lev;
`ifdef PI_SYNC_EN
  logic [1:7] m_sync [2];
`endif
  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:7] lvm(input int n);
    logic [1:7] v = '0;
    v[n] = 1'b1;
    return v;
  endfunction
  function automatic logic [0:35] cono(input logic [22:28] cmd, input logic [1:7] lv);
    logic [0:35] d = '0;
    d[22:28] = cmd;
    d[29:35] = lv;
    return d;
  endfunction
  function automatic int m_cur();
    for (int n = 1; n <= 7; n++) if (m_hold[n]) return n;
    return 0;
  endfunction
  function automatic logic [0:35] m_status();
    logic [0:35] s = '0;
    for (int n = 1; n <= 7; n++) begin
      s[10+n] = m_prog[n];
      s[20+n] = m_hold[n];
      s[28+n] = m_on[n];
    end
    s[28] = m_sys;
    return s;
  endfunction
  task automatic m_clear();
    for (int n = 1; n <= 7; n++) begin
      m_prog[n] = 0;
      m_hold[n] = 0;
      m_on[n] = 0;
    end
    m_sys = 0;
    m_offer = 0;
    m_lev = 0;
  endtask
  task automatic step(input bit w, input logic [0:35] d, input logic [1:7] b, input bit a, input bit ds,
                      input bit ce = 1'b1, input bit r = 1'b1);
    logic [1:7] eff;
    bit pend [1:7];
    int cur, best;
    rst = r;
    clken = ce;
    pi.pi_wr = w;
    pi.dp = d;
    pi.bus_pi_req_in = b;
    pi.pi_ack = a;
    pi.pi_dismiss = ds;
`ifdef PI_SYNC_EN
    eff = m_sync[1];
    if (!r) begin
      m_sync[0] = '0;
      m_sync[1] = '0;
    end else if (ce) begin
      m_sync[1] = m_sync[0];
      m_sync[0] = b;
    end
`else
    eff = b;
`endif
    if (!r) m_clear();
    else if (ce) begin
      if (w && d[23]) m_clear();
      else begin
        cur = m_cur();
        best = 0;
        for (int n = 7; n >= 1; n--) begin
          pend[n] = (eff[n] | m_prog[n]) & m_on[n] & m_sys;
          if (pend[n] && (cur == 0 || n < cur)) best = n;
        end
        if (ds && cur != 0) m_hold[cur] = 0;
        if (m_offer) begin
          if (a) begin
            m_hold[m_lev] = 1;
            m_offer = 0;
          end else if (!pend[m_lev]) m_offer = 0;
        end else if (best != 0) begin
          m_offer = 1;
          m_lev = best;
        end
        if (w) for (int n = 1; n <= 7; n++) if (d[28+n]) begin
          if (d[22]) m_prog[n] = 0;
          if (d[24]) m_prog[n] = 1;
          if (d[25]) m_on[n] = 1;
          if (d[26]) m_on[n] = 0;
        end
        if (w && d[28]) m_sys = 1;
        else if (w && d[27]) m_sys = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("pi_req", 36'(pi.pi_req), 36'(m_offer));
    check("pi_lev", 36'(pi.pi_lev), m_offer ? 36'(m_lev) : 36'd0);
    check("pi_cur", 36'(pi.pi_cur), 36'(m_cur()));
    check("pi_status", pi.pi_status, m_status());
  endtask
  initial begin
    logic [0:35] d;
    pi.pi_wr = 0;
    pi.dp = '0;
    pi.bus_pi_req_in = '0;
    pi.pi_ack = 0;
    pi.pi_dismiss = 0;
    @(negedge clk);
    step(0, '0, 7'h7F, 0, 0, 1, 0);
    step(0, '0, 7'h7F, 0, 0, 1, 0);
    check("rst_req", 36'(pi.pi_req), 36'd0);
    check("rst_status", pi.pi_status, 36'd0);
    step(1, cono(7'b0001001, 7'h7F), '0, 0, 0);
    step(0, '0, lvm(5), 0, 0);
`ifndef PI_SYNC_EN
    check("lev5_offer", 36'(pi.pi_lev), 36'd5);
`endif
    step(0, '0, lvm(5), 1, 0);
`ifndef PI_SYNC_EN
    check("lev5_cur", 36'(pi.pi_cur), 36'd5);
    check("lev5_stat25", 36'(pi.pi_status[25]), 36'd1);
`endif
    step(0, '0, lvm(6), 0, 0);
    step(0, '0, lvm(6), 0, 0);
    check("lev6_blocked", 36'(pi.pi_req), 36'd0);
    step(0, '0, lvm(2), 0, 0);
`ifndef PI_SYNC_EN
    check("lev2_offer", 36'(pi.pi_lev), 36'd2);
`endif
    step(0, '0, lvm(2), 1, 0);
    step(0, '0, '0, 0, 1);
    check("dismiss_cur5", 36'(pi.pi_cur), 36'd5);
    step(1, cono(7'b0010000, lvm(3)), '0, 0, 0);
    check("prog3_stat", 36'(pi.pi_status[13]), 36'd1);
    step(0, '0, '0, 0, 0);
    step(0, '0, '0, 1, 0);
    step(0, '0, '0, 0, 0);
    step(0, '0, '0, 0, 0);
    check("prog3_norereq", 36'(pi.pi_req), 36'd0);
    step(0, '0, '0, 0, 1);
    step(0, '0, '0, 0, 0);
    check("prog3_rereq", 36'(pi.pi_lev), 36'd3);
    step(1, cono(7'b0100000, '0), '0, 0, 0);
    step(1, cono(7'b0001001, 7'h7F), '0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, lvm(6), i == 3, 0);
    for (int i = 0; i < 4; i++) step(0, '0, lvm(4), i == 3, i == 3);
    check("ackdis_hold4", 36'(pi.pi_status[21:27]), 36'(lvm(4)));
    step(0, '0, lvm(4), 0, 1);
    for (int i = 0; i < 3; i++) step(0, '0, lvm(4), 0, 0);
    check("req4_before_clr", 36'(pi.pi_req), 36'd1);
    step(1, cono(7'b0100000, '0), lvm(4), 0, 0);
    check("clr_req", 36'(pi.pi_req), 36'd0);
    check("clr_status", pi.pi_status, 36'd0);
    step(1, cono(7'b0001001, 7'h7F), '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, lvm(1), 0, 0, 0);
    check("clken_frozen", 36'(pi.pi_req), 36'd0);
    for (int i = 0; i < 3000; i++) begin
      d = {$urandom, $urandom};
      if ($urandom_range(0, 19) != 0) d[23] = 1'b0;
      if ($urandom_range(0, 2) == 0) d[28] = 1'b1;
      step($urandom_range(0, 9) == 0, d, 7'($urandom_range(0, 3) == 0 ? $urandom : 0),
           $urandom_range(0, 2) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 6) != 0, $urandom_range(0, 199) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/pi_ctrl.md
Name: pi_ctrl

Overview:
Priority-interrupt controller for the KS-10 CPU. It collects the seven-level PI requests from the APR's bus_pi_req_out and from other bus devices, adds programmed requests written by CONO PI, and arbitrates among them with level 1 as the highest priority. It runs a request/acknowledge handshake with the microcode sequencer and tracks in-progress (held) levels until they are dismissed. It sits beside APR in the cpu directory and drives the microcode interrupt-request condition.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on bus_pi_req_in; used only when PI_SYNC_EN is defined.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-low reset
clken  input  1  clock enable; all state updates are qualified by it except reset
pi_wr  input  1  CONO PI write strobe; decoded dp is applied on this cycle
dp  input  [0:35]  data path; command bits [22:28], level select [29:35] = levels 1..7
bus_pi_req_in  input  [1:7]  OR of device PI requests, including APR bus_pi_req_out
pi_ack  input  1  CPU accepts the offered interrupt (single-cycle pulse)
pi_dismiss  input  1  dismiss the highest-priority held level (single-cycle pulse)
pi_req  output  1  interrupt offered to the CPU
pi_lev  output  [0:2]  level being offered (1..7); 0 when pi_req=0
pi_cur  output  [0:2]  highest-priority held level; 0 = none
pi_status  output  [0:35]  CONI PI read-back

Behaviour:
- Registers:
  - prog[1:7]: programmed requests.
  - hold[1:7]: in progress.
  - lvl_on[1:7]: levels enabled.
  - sys_on.
  - state, one of IDLE or REQ.
  - cur_lev[0:2].
- Reset (rst=0 at a clk edge): all registers clear, state=IDLE. Outputs are then pi_req=0, pi_lev=0, pi_cur=0, pi_status=0. Reset takes effect mid-handshake as well and overrides clken.
- CONO decode when pi_wr & clken. The level mask is L=dp[29:35].
  - dp[22]: prog &= ~L.
  - dp[23]: clear system. prog, hold, lvl_on and sys_on are cleared, state goes to IDLE, and all other bits are ignored.
  - dp[24]: prog |= L.
  - dp[25]: lvl_on |= L.
  - dp[26]: lvl_on &= ~L.
  - dp[27]: sys_on=0.
  - dp[28]: sys_on=1.
  - If dp[27] and dp[28] are both set, dp[28] wins.
  - If dp[25] and dp[26] are both set for the same level, off wins.
- Request vector: pend[n] = (bus_pi_req_in[n] | prog[n]) & lvl_on[n] & sys_on.
- Eligibility: level n is eligible if pend[n] is set and n is numerically lower than pi_cur (any n if pi_cur=0). best = the lowest-numbered eligible level.
- IDLE state: if best exists, latch cur_lev=best and go to REQ. pi_req is registered, so it rises 1 clken cycle after the request is present.
- REQ state: pi_req=1 and pi_lev=cur_lev. pi_lev stays stable while in REQ.
  - A higher-priority arrival does not retarget the offer; it is serviced after the ack.
  - pi_ack: set hold[cur_lev], go to IDLE, and pi_req=0 on the next cycle. A programmed request stays in prog until software drops it.
  - If pend[cur_lev] falls (or sys_on=0 / clear) without pi_ack in the same cycle: withdraw, go to IDLE, and pi_req=0 next cycle.
  - If pi_ack coincides with a withdraw, the ack wins.
- pi_dismiss clears the lowest-numbered set bit of hold. It is a no-op if hold=0.
- If pi_ack and pi_dismiss occur in the same cycle, the dismiss is applied first to the old hold, then the ack bit is set.
- pi_cur is combinational from hold.
- pi_status layout:
  - [11:17] = prog
  - [21:27] = hold
  - [28] = sys_on
  - [29:35] = lvl_on
  - all other bits are 0.
- With clken=0, state is frozen. pi_ack, pi_dismiss and pi_wr are ignored when clken=0.

Optional Feature:
PI_SYNC_EN.
- Defined: bus_pi_req_in passes through SYNC_STAGES flops, each clocked on clk and gated by clken, before the pend computation. This adds SYNC_STAGES cycles of request latency. The flops are reset to 0.
- Undefined: bus_pi_req_in is used directly, with 1-cycle latency to pi_req.

Test Plan:
1. Reset with rst=0 for 2 cycles, bus_pi_req_in=7'h7F -> pi_req=0, pi_lev=0, pi_cur=0, pi_status=36'o0.
2. pi_wr with dp[25]=1, dp[28]=1, dp[29:35]=7'h7F; then bus_pi_req_in level 5 -> pi_req=1 with pi_lev=5 one cycle later. After pi_ack: pi_req=0, pi_cur=5, pi_status[25]=1, pi_status[28]=1.
3. With level 5 held:
   - bus level 6 asserted -> no pi_req.
   - bus level 2 asserted -> pi_req=1, pi_lev=2. After pi_ack: pi_cur=2, hold = levels 2 and 5.
   - pi_dismiss -> pi_cur=5.
4. pi_wr with dp[24]=1 and level 3 selected -> pi_status[13]=1 and pi_req with pi_lev=3. After pi_ack, the request persists: prog[3] remains set and no re-request occurs while level 3 is held. After pi_dismiss -> a new request at level 3.
5. In REQ at level 4, pi_wr with dp[23]=1 -> next cycle pi_req=0 and pi_status=0. A simultaneous pi_ack+pi_dismiss with hold={6} and cur_lev=4 gives hold={4}.
6. PI_SYNC_EN defined, SYNC_STAGES=2, bus level 1 rises at cycle N -> pi_req=1 at cycle N+3. With clken held low, no advance occurs.
